// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
//   Definitions shared by the draw arbiter, its address generator and every
//   draw source, so that source SOURCE_ID parameters and the arbiter's grant
//   order agree.
//
//   Contents:
//     NATIVE_DRAW_WIDTH / NATIVE_DRAW_HEIGHT : native framebuffer geometry
//     FB_ADDR_W      : linear framebuffer address width
//     COORD_W        : width of the x / y coordinates on the write bus
//     SRC_*          : source IDs, granted in ascending order each frame
//     draw_state_t   : arbiter FSM state encoding
//     sat_inc16()    : saturating 16-bit increment
// -----------------------------------------------------------------------------
package draw_pkg;

  localparam int NATIVE_DRAW_WIDTH  = 640;
  localparam int NATIVE_DRAW_HEIGHT = 480;
  localparam int FB_ADDR_W          = 19;
  localparam int COORD_W            = 10;

  // Source IDs; the arbiter grants the bus to them in ascending order.
  localparam int SRC_STARFIELD    = 0;
  localparam int SRC_SPRITES      = 1;
  localparam int SRC_HUD          = 2;
  localparam int SRC_OVERLAY      = 3;
  localparam int NUM_DRAW_SOURCES = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_GRANT_WAIT = 3'd2,
    ST_STREAM     = 3'd3,
    ST_NEXT_SRC   = 3'd4,
    ST_DONE       = 3'd5
  } draw_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/draw_addr_gen.sv
// -----------------------------------------------------------------------------
// draw_addr_gen
//   Registered pixel stage between the arbiter's source mux and the
//   framebuffer write port. Checks the coordinate against the framebuffer
//   bounds and computes the linear address y*DRAW_WIDTH + x. Everything is
//   registered, giving a fixed one-cycle latency from valid_i to we_o.
//
//   Ports:
//     clk, resetN : clock, asynchronous active-low reset
//     valid_i     : a pixel is presented this cycle
//     x_i, y_i    : pixel coordinate (COORD_W bits each)
//     data_i      : pixel colour
//     we_o        : framebuffer write strobe (in-range pixel accepted)
//     addr_o      : linear framebuffer address
//     data_o      : framebuffer write data
//     drop_o      : one-cycle pulse for an out-of-range pixel
// -----------------------------------------------------------------------------
module draw_addr_gen
  import draw_pkg::*;
#(
  parameter int COLOR_DEPTH = 9,
  parameter int DRAW_WIDTH  = NATIVE_DRAW_WIDTH,
  parameter int DRAW_HEIGHT = NATIVE_DRAW_HEIGHT
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   valid_i,
  input  logic [COORD_W-1:0]     x_i,
  input  logic [COORD_W-1:0]     y_i,
  input  logic [COLOR_DEPTH-1:0] data_i,
  output logic                   we_o,
  output logic [FB_ADDR_W-1:0]   addr_o,
  output logic [COLOR_DEPTH-1:0] data_o,
  output logic                   drop_o
);

  logic [FB_ADDR_W-1:0]   x_ext;
  logic [FB_ADDR_W-1:0]   y_ext;
  logic [FB_ADDR_W-1:0]   lin_addr;
  logic                   in_range;

  logic                   we_d,   we_q;
  logic                   drop_d, drop_q;
  logic [FB_ADDR_W-1:0]   addr_d, addr_q;
  logic [COLOR_DEPTH-1:0] data_d, data_q;

  // Widen before multiplying so the full 19-bit product is kept.
  assign x_ext = FB_ADDR_W'(x_i);
  assign y_ext = FB_ADDR_W'(y_i);

  if (DRAW_WIDTH == NATIVE_DRAW_WIDTH) begin : g_native
    // 640 = 512 + 128: two shifted copies of y plus x, no multiplier.
    assign lin_addr = (y_ext << 9) + (y_ext << 7) + x_ext;
  end else begin : g_generic
    assign lin_addr = y_ext * FB_ADDR_W'(DRAW_WIDTH) + x_ext;
  end

  // One extra bit on the compare so a full 10-bit bound would still fit.
  assign in_range = ({1'b0, x_i} < 11'(DRAW_WIDTH)) &&
                    ({1'b0, y_i} < 11'(DRAW_HEIGHT));

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that
    // leaves one unassigned would make synthesis infer a latch.
    we_d   = 1'b0;
    drop_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (valid_i) begin
      we_d   = in_range;
      drop_d = !in_range;
      if (in_range) begin
        addr_d = lin_addr;
        data_d = data_i;
      end
    end
  end

  // NOTE: clocked state uses non-blocking (<=) assignments so all flops
  // sample their pre-edge inputs; blocking here creates order-dependent
  // simulation and sim/synthesis mismatches.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      we_q   <= 1'b0;
      drop_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      drop_q <= drop_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign we_o   = we_q;
  assign drop_o = drop_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/draw_arbiter.sv
// -----------------------------------------------------------------------------
// draw_arbiter
//   Owns the shared draw write bus. On each frame pulse it optionally clears
//   the back framebuffer to BG_COLOR, then grants the bus to each draw source
//   in ascending ID order, forwarding the granted source's pixels to the
//   framebuffer write port. A source that does not start within WAIT_TIMEOUT
//   cycles is skipped. frame_done pulses once all sources are finished.
//
//   Ports:
//     clk, resetN       : clock, asynchronous active-low reset
//     frame             : one-cycle start-of-frame pulse
//     write_source_sel  : ID of the source currently granted the bus
//     write_awaited     : arbiter is waiting for / accepting the granted stream
//     write_active      : granted source presents a valid pixel this cycle
//     write_color_data  : pixel colour from the granted source
//     write_x_addr      : pixel x
//     write_y_addr      : pixel y
//     fb_we/addr/data   : registered framebuffer write port
//     frame_done        : one-cycle pulse at end of frame
//     overrun           : sticky, frame pulse seen while not idle
//     dropped_cnt       : saturating count of out-of-range pixels
// -----------------------------------------------------------------------------
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int                     NUM_SOURCES  = NUM_DRAW_SOURCES,
  parameter int                     SEL_W        = 2,
  parameter int                     COLOR_DEPTH  = 9,
  parameter int                     DRAW_WIDTH   = NATIVE_DRAW_WIDTH,
  parameter int                     DRAW_HEIGHT  = NATIVE_DRAW_HEIGHT,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR     = '0,
  parameter bit                     CLEAR_EN     = 1'b1,
  parameter int                     WAIT_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame,
  output logic [SEL_W-1:0]       write_source_sel,
  output logic                   write_awaited,
  input  logic                   write_active,
  input  logic [COLOR_DEPTH-1:0] write_color_data,
  input  logic [COORD_W-1:0]     write_x_addr,
  input  logic [COORD_W-1:0]     write_y_addr,
  output logic                   fb_we,
  output logic [FB_ADDR_W-1:0]   fb_addr,
  output logic [COLOR_DEPTH-1:0] fb_data,
  output logic                   frame_done,
  output logic                   overrun,
  output logic [15:0]            dropped_cnt
);

  localparam int TO_W = $clog2(WAIT_TIMEOUT + 1);

  draw_state_t            state_d,   state_q;
  logic [SEL_W-1:0]       sel_d,     sel_q;
  logic [TO_W-1:0]        timeout_d, timeout_q;
  logic [COORD_W-1:0]     clr_x_d,   clr_x_q;
  logic [COORD_W-1:0]     clr_y_d,   clr_y_q;
  logic                   overrun_d, overrun_q;
  logic [15:0]            dropped_d, dropped_q;

  // Address generator inputs: clear counter or the bus, chosen by state.
  logic                   ag_valid;
  logic [COORD_W-1:0]     ag_x;
  logic [COORD_W-1:0]     ag_y;
  logic [COLOR_DEPTH-1:0] ag_data;
  logic                   ag_drop;

  logic clr_last;
  logic sel_last;
  logic wait_expired;

  assign clr_last     = (clr_x_q == COORD_W'(DRAW_WIDTH - 1)) &&
                        (clr_y_q == COORD_W'(DRAW_HEIGHT - 1));
  assign sel_last     = (sel_q == SEL_W'(NUM_SOURCES - 1));
  assign wait_expired = (timeout_q == TO_W'(WAIT_TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sel_q     <= '0;
      timeout_q <= '0;
      clr_x_q   <= '0;
      clr_y_q   <= '0;
      overrun_q <= 1'b0;
      dropped_q <= '0;
    end else begin
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
      clr_x_q   <= clr_x_d;
      clr_y_q   <= clr_y_d;
      overrun_q <= overrun_d;
      dropped_q <= dropped_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    timeout_d = timeout_q;
    clr_x_d   = clr_x_q;
    clr_y_d   = clr_y_q;

    unique case (state_q)
      ST_IDLE: begin
        if (frame) begin
          sel_d     = '0;
          timeout_d = '0;
          clr_x_d   = '0;
          clr_y_d   = '0;
          state_d   = CLEAR_EN ? ST_CLEAR : ST_GRANT_WAIT;
        end
      end

      ST_CLEAR: begin
        if (clr_last) begin
          sel_d     = '0;
          timeout_d = '0;
          state_d   = ST_GRANT_WAIT;
        end else if (clr_x_q == COORD_W'(DRAW_WIDTH - 1)) begin
          clr_x_d = '0;
          clr_y_d = clr_y_q + 1'b1;
        end else begin
          clr_x_d = clr_x_q + 1'b1;
        end
      end

      ST_GRANT_WAIT: begin
        // A pixel arriving on the last wait cycle still wins over the skip.
        if (write_active) begin
          state_d = ST_STREAM;
        end else if (wait_expired) begin
          state_d = ST_NEXT_SRC;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end

      ST_STREAM: begin
        if (!write_active) begin
          state_d = ST_NEXT_SRC;
        end
      end

      ST_NEXT_SRC: begin
        // Grant drops this cycle; sel only moves once awaited is low.
        if (sel_last) begin
          state_d = ST_DONE;
        end else begin
          sel_d     = sel_q + 1'b1;
          timeout_d = '0;
          state_d   = ST_GRANT_WAIT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A frame pulse outside IDLE (including the DONE cycle) is dropped.
    overrun_d = overrun_q | (frame && (state_q != ST_IDLE));
    dropped_d = ag_drop ? sat_inc16(dropped_q) : dropped_q;
  end

  // ---------------------------------------------------------------------------
  // Outputs and pixel-source mux
  // ---------------------------------------------------------------------------
  always_comb begin
    write_awaited = 1'b0;
    frame_done    = 1'b0;
    ag_valid      = 1'b0;
    ag_x          = clr_x_q;
    ag_y          = clr_y_q;
    ag_data       = BG_COLOR;

    unique case (state_q)
      ST_CLEAR: begin
        ag_valid = 1'b1;
      end
      ST_GRANT_WAIT, ST_STREAM: begin
        write_awaited = 1'b1;
        ag_valid      = write_active;
        ag_x          = write_x_addr;
        ag_y          = write_y_addr;
        ag_data       = write_color_data;
      end
      ST_DONE: begin
        frame_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  draw_addr_gen #(
    .COLOR_DEPTH (COLOR_DEPTH),
    .DRAW_WIDTH  (DRAW_WIDTH),
    .DRAW_HEIGHT (DRAW_HEIGHT)
  ) u_addr_gen (
    .clk     (clk),
    .resetN  (resetN),
    .valid_i (ag_valid),
    .x_i     (ag_x),
    .y_i     (ag_y),
    .data_i  (ag_data),
    .we_o    (fb_we),
    .addr_o  (fb_addr),
    .data_o  (fb_data),
    .drop_o  (ag_drop)
  );

  assign write_source_sel = sel_q;
  assign overrun          = overrun_q;
  assign dropped_cnt      = dropped_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_draw_arbiter
//   Directed bench for draw_arbiter. Two instances share clock and reset:
//     dut_a : 640x480, four sources, no clear (streaming, range, overrun,
//             reset-mid-stream)
//     dut_b : 8x4, one silent source, clear enabled (clear sweep, grant
//             timeout, frame pulse on the DONE cycle)
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_draw_arbiter;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  // dut_a
  logic        frame_a, active_a, awaited_a, fb_we_a, done_a, overrun_a;
  logic [1:0]  sel_a;
  logic [8:0]  color_a, fb_data_a;
  logic [9:0]  x_a, y_a;
  logic [18:0] fb_addr_a;
  logic [15:0] dropped_a;

  // dut_b
  logic        frame_b, active_b, awaited_b, fb_we_b, done_b, overrun_b;
  logic [1:0]  sel_b;
  logic [8:0]  color_b, fb_data_b;
  logic [9:0]  x_b, y_b;
  logic [18:0] fb_addr_b;
  logic [15:0] dropped_b;

  draw_arbiter #(
    .NUM_SOURCES  (4),
    .CLEAR_EN     (1'b0),
    .WAIT_TIMEOUT (1024)
  ) dut_a (
    .clk              (clk),
    .resetN           (resetN),
    .frame            (frame_a),
    .write_source_sel (sel_a),
    .write_awaited    (awaited_a),
    .write_active     (active_a),
    .write_color_data (color_a),
    .write_x_addr     (x_a),
    .write_y_addr     (y_a),
    .fb_we            (fb_we_a),
    .fb_addr          (fb_addr_a),
    .fb_data          (fb_data_a),
    .frame_done       (done_a),
    .overrun          (overrun_a),
    .dropped_cnt      (dropped_a)
  );

  draw_arbiter #(
    .NUM_SOURCES  (1),
    .DRAW_WIDTH   (8),
    .DRAW_HEIGHT  (4),
    .CLEAR_EN     (1'b1),
    .WAIT_TIMEOUT (1024)
  ) dut_b (
    .clk              (clk),
    .resetN           (resetN),
    .frame            (frame_b),
    .write_source_sel (sel_b),
    .write_awaited    (awaited_b),
    .write_active     (active_b),
    .write_color_data (color_b),
    .write_x_addr     (x_b),
    .write_y_addr     (y_b),
    .fb_we            (fb_we_b),
    .fb_addr          (fb_addr_b),
    .fb_data          (fb_data_b),
    .frame_done       (done_b),
    .overrun          (overrun_b),
    .dropped_cnt      (dropped_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel_a(input int x, input int y, input int c);
    active_a = 1'b1;
    x_a      = 10'(x);
    y_a      = 10'(y);
    color_a  = 9'(c);
  endtask

  task automatic idle_bus_a();
    active_a = 1'b0;
    x_a      = 'x;
    y_a      = 'x;
    color_a  = 'x;
  endtask

  initial begin
    int n, writes, done_cnt, extra_done, extra_aw, fb_seen;
    int we_cnt, first_we, last_we, first_aw, last_aw, done_idx;
    int addr_bad, data_bad, sel_bad, late_we, late_aw;
    int px, py, pc;
    logic [18:0] exp_clr;

    // ------------------------------------------------------------ reset
    resetN  = 1'b0;
    frame_a = 1'b0;
    frame_b = 1'b0;
    idle_bus_a();
    active_b = 1'b0;
    color_b  = 9'h1FF;
    x_b      = '0;
    y_b      = '0;
    step();
    step();
    check("rst_fb_we_a",    32'(fb_we_a),    32'd0);
    check("rst_fb_addr_a",  32'(fb_addr_a),  32'd0);
    check("rst_fb_data_a",  32'(fb_data_a),  32'd0);
    check("rst_awaited_a",  32'(awaited_a),  32'd0);
    check("rst_sel_a",      32'(sel_a),      32'd0);
    check("rst_done_a",     32'(done_a),     32'd0);
    check("rst_overrun_a",  32'(overrun_a),  32'd0);
    check("rst_dropped_a",  32'(dropped_a),  32'd0);
    check("rst_fb_we_b",    32'(fb_we_b),    32'd0);
    check("rst_awaited_b",  32'(awaited_b),  32'd0);
    resetN = 1'b1;
    step();

    // ------------------------------------------------- clear + timeout (b)
    we_cnt = 0; first_we = -1; last_we = -1; first_aw = -1; last_aw = -1;
    done_idx = -1; done_cnt = 0; addr_bad = 0; data_bad = 0; sel_bad = 0;
    late_we = 0; late_aw = 0; exp_clr = '0;
    frame_b = 1'b1;
    step();
    for (int i = 1; i <= 1100; i++) begin
      if (i > 1) step();
      frame_b = 1'b0;
      if (fb_we_b === 1'b1) begin
        if (first_we < 0) first_we = i;
        last_we = i;
        if (fb_addr_b !== exp_clr) addr_bad++;
        if (fb_data_b !== 9'h000) data_bad++;
        exp_clr++;
        we_cnt++;
        if (done_cnt > 0) late_we++;
      end
      if (awaited_b === 1'b1) begin
        if (first_aw < 0) first_aw = i;
        last_aw = i;
        if (sel_b !== 2'd0) sel_bad++;
        if (done_cnt > 0) late_aw++;
      end
      if (done_b === 1'b1) begin
        done_cnt++;
        done_idx = i;
        frame_b  = 1'b1;   // lands on the DONE->IDLE edge
      end
    end
    check("clr_write_count",  32'(we_cnt),   32'd32);
    check("clr_first_write",  32'(first_we), 32'd2);
    check("clr_last_write",   32'(last_we),  32'd33);
    check("clr_addr_seq_bad", 32'(addr_bad), 32'd0);
    check("clr_data_bad",     32'(data_bad), 32'd0);
    check("to_first_awaited", 32'(first_aw), 32'd33);
    check("to_last_awaited",  32'(last_aw),  32'd1056);
    check("to_sel_bad",       32'(sel_bad),  32'd0);
    check("clr_done_count",   32'(done_cnt), 32'd1);
    check("clr_done_cycle",   32'(done_idx), 32'd1058);
    check("done_edge_no_we",  32'(late_we),  32'd0);
    check("done_edge_no_aw",  32'(late_aw),  32'd0);
    check("done_edge_ovr_b",  32'(overrun_b), 32'd1);

    // ------------------------------------ three pixels, then drops (a)
    frame_a = 1'b1;
    step();
    frame_a = 1'b0;
    check("b_awaited_s0", 32'(awaited_a), 32'd1);
    check("b_sel_s0",     32'(sel_a),     32'd0);
    pixel_a(10, 20, 9'h011);
    step();
    check("b_we_p0",   32'(fb_we_a),   32'd1);
    check("b_addr_p0", 32'(fb_addr_a), 32'd12810);
    check("b_data_p0", 32'(fb_data_a), 32'h011);
    pixel_a(639, 479, 9'h122);
    step();
    check("b_we_p1",   32'(fb_we_a),   32'd1);
    check("b_addr_p1", 32'(fb_addr_a), 32'd307199);
    check("b_data_p1", 32'(fb_data_a), 32'h122);
    pixel_a(0, 0, 9'h1A5);
    step();
    check("b_we_p2",   32'(fb_we_a),   32'd1);
    check("b_addr_p2", 32'(fb_addr_a), 32'd0);
    check("b_data_p2", 32'(fb_data_a), 32'h1A5);
    idle_bus_a();
    step();
    check("b_gap_we",      32'(fb_we_a),   32'd0);
    check("b_gap_awaited", 32'(awaited_a), 32'd0);
    check("b_gap_sel",     32'(sel_a),     32'd0);
    step();
    check("b_awaited_s1", 32'(awaited_a), 32'd1);
    check("b_sel_s1",     32'(sel_a),     32'd1);
    check("c_dropped_0",  32'(dropped_a), 32'd0);
    pixel_a(640, 0, 9'h0F0);
    step();
    check("c_no_we_x640", 32'(fb_we_a), 32'd0);
    pixel_a(0, 480, 9'h00F);
    step();
    check("c_no_we_y480", 32'(fb_we_a), 32'd0);
    idle_bus_a();
    step();
    check("c_dropped_2",  32'(dropped_a), 32'd2);
    check("c_gap_awaited", 32'(awaited_a), 32'd0);

    // Sources 2 and 3 stay silent and are skipped after 1024 cycles each.
    n = 0;
    fb_seen = 0;
    while (done_a !== 1'b1 && n < 2200) begin
      step();
      n++;
      if (fb_we_a === 1'b1) fb_seen++;
    end
    check("c_done_steps",   32'(n),         32'd2051);
    check("c_skip_no_we",   32'(fb_seen),   32'd0);
    check("c_overrun_zero", 32'(overrun_a), 32'd0);
    step();

    // -------------------- four sources x 50 pixels, overrun pulse (a)
    writes = 0;
    frame_a = 1'b1;
    step();
    frame_a = 1'b0;
    for (int s = 0; s < 4; s++) begin
      n = 0;
      while (!(awaited_a === 1'b1 && sel_a === 2'(s)) && n < 20) begin
        step();
        n++;
      end
      check("d_grant_awaited", 32'(awaited_a), 32'd1);
      check("d_grant_sel",     32'(sel_a),     32'(s));
      for (int p = 0; p < 50; p++) begin
        px = int'($urandom_range(0, 639));
        py = int'($urandom_range(0, 479));
        pc = int'($urandom_range(0, 511));
        pixel_a(px, py, pc);
        if (s == 1 && p == 10) frame_a = 1'b1;
        step();
        frame_a = 1'b0;
        check("d_we",   32'(fb_we_a),   32'd1);
        check("d_addr", 32'(fb_addr_a), 32'(py * 640 + px));
        check("d_data", 32'(fb_data_a), 32'(pc));
        if (fb_we_a === 1'b1) writes++;
        if (s == 1 && p == 10) check("e_overrun_set", 32'(overrun_a), 32'd1);
      end
      idle_bus_a();
      step();
      check("d_gap_awaited", 32'(awaited_a), 32'd0);
      check("d_gap_we",      32'(fb_we_a),   32'd0);
      step();
      if (s < 3) begin
        check("d_next_awaited", 32'(awaited_a), 32'd1);
        check("d_next_sel",     32'(sel_a),     32'(s + 1));
      end else begin
        check("d_frame_done", 32'(done_a), 32'd1);
      end
    end
    check("d_write_total", 32'(writes), 32'd200);
    extra_done = 0;
    extra_aw   = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_a !== 1'b0) extra_done++;
      if (awaited_a !== 1'b0) extra_aw++;
    end
    check("e_single_done",   32'(extra_done), 32'd0);
    check("e_no_new_frame",  32'(extra_aw),   32'd0);
    check("e_overrun_stays", 32'(overrun_a),  32'd1);

    // ------------------------------------------ reset mid-stream (a)
    frame_a = 1'b1;
    step();
    frame_a = 1'b0;
    pixel_a(5, 1, 9'h0AA);
    step();
    check("f_we_before",   32'(fb_we_a),   32'd1);
    check("f_addr_before", 32'(fb_addr_a), 32'd645);
    pixel_a(6, 1, 9'h0AB);
    #2;
    resetN = 1'b0;
    #1;
    check("f_async_we",      32'(fb_we_a),   32'd0);
    check("f_async_awaited", 32'(awaited_a), 32'd0);
    check("f_async_addr",    32'(fb_addr_a), 32'd0);
    check("f_async_overrun", 32'(overrun_a), 32'd0);
    step();
    check("f_held_we", 32'(fb_we_a), 32'd0);
    #2;
    resetN = 1'b1;
    idle_bus_a();
    step();
    check("f_idle_awaited", 32'(awaited_a), 32'd0);
    frame_a = 1'b1;
    step();
    frame_a = 1'b0;
    check("f_restart_awaited", 32'(awaited_a), 32'd1);
    check("f_restart_sel",     32'(sel_a),     32'd0);
    pixel_a(1, 0, 9'h155);
    step();
    check("f_restart_we",   32'(fb_we_a),   32'd1);
    check("f_restart_addr", 32'(fb_addr_a), 32'd1);
    check("f_restart_data", 32'(fb_data_a), 32'h155);
    idle_bus_a();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
